// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline freeze/flush sequencer: FSM state encoding
// and register-index width.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Combinational RAW-hazard detector for the ID stage. With forwarding active
// only a load still in EXE forces a stall; without it, any pending writer does.
module hazard_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 id_valid,
    input  logic                 fwd_en,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    output logic                 raw
);

    logic exe_hit;
    logic mem_hit;
    logic exe_live;
    logic mem_live;

    assign exe_live = fwd_en ? (exe_wb_en & exe_mem_r_en) : exe_wb_en;
    assign mem_live = ~fwd_en & mem_wb_en;

    assign exe_hit = exe_live & ((id_valid & (id_src1 == exe_dest)) |
                                 (id_two_src & (id_src2 == exe_dest)));
    assign mem_hit = mem_live & ((id_valid & (id_src1 == mem_dest)) |
                                 (id_two_src & (id_src2 == mem_dest)));

    assign raw = exe_hit | mem_hit;

endmodule

// File: rtl/pipeline_ctrl.sv
// Freeze/flush sequencer for the IF/ID/EXE/MEM stage registers and the data-memory
// request handshake. Optional PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 id_valid,
    input  logic                 fwd_en,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 branch_taken,
    input  logic                 mem_r_en,
    input  logic                 mem_w_en,
    input  logic                 mem_ready,
    output logic                 pc_freeze,
    output logic                 if_freeze,
    output logic                 id_freeze,
    output logic                 exe_freeze,
    output logic                 mem_freeze,
    output logic                 if_flush,
    output logic                 id_flush,
    output logic                 mem_req,
    output logic                 mem_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

    state_t              state, state_nxt;
    logic [WCNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                raw, mem_op, raw_stall;
    logic                pc_frz_c, if_frz_c, back_frz_c, if_fl_c, id_fl_c, req_c, tmo_c;

    hazard_unit u_hazard (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_valid     (id_valid),
        .fwd_en       (fwd_en),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .raw          (raw)
    );

    assign mem_op    = mem_r_en | mem_w_en;
    // A taken branch squashes the younger instruction, so its hazard is moot.
    assign raw_stall = raw & ~branch_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pc_frz_c     = 1'b0;
        if_frz_c     = 1'b0;
        back_frz_c   = 1'b0;
        if_fl_c      = 1'b0;
        id_fl_c      = 1'b0;
        req_c        = 1'b0;
        tmo_c        = 1'b0;
        case (state)
            ST_RUN: begin
                req_c = mem_op;
                if (mem_op && !mem_ready) begin
                    pc_frz_c     = 1'b1;
                    if_frz_c     = 1'b1;
                    back_frz_c   = 1'b1;
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = WCNT_W'(1);
                end else begin
                    pc_frz_c = raw_stall;
                    if_frz_c = raw_stall;
                    if_fl_c  = branch_taken;
                    id_fl_c  = branch_taken | raw_stall;
                end
            end
            ST_WAIT: begin
                req_c        = 1'b1;
                wait_cnt_nxt = wait_cnt + WCNT_W'(1);
                if (mem_ready) begin
                    pc_frz_c  = raw_stall;
                    if_frz_c  = raw_stall;
                    if_fl_c   = branch_taken;
                    id_fl_c   = branch_taken | raw_stall;
                    state_nxt = ST_RUN;
                end else begin
                    pc_frz_c   = 1'b1;
                    if_frz_c   = 1'b1;
                    back_frz_c = 1'b1;
                    if (wait_cnt == WCNT_W'(TIMEOUT_CYCLES)) begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                pc_frz_c   = 1'b1;
                if_frz_c   = 1'b1;
                back_frz_c = 1'b1;
                tmo_c      = 1'b1;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Outputs are forced low for as long as reset is held, not just after an edge.
    assign pc_freeze   = rst & pc_frz_c;
    assign if_freeze   = rst & if_frz_c;
    assign id_freeze   = rst & back_frz_c;
    assign exe_freeze  = rst & back_frz_c;
    assign mem_freeze  = rst & back_frz_c;
    assign if_flush    = rst & if_fl_c;
    assign id_flush    = rst & id_fl_c;
    assign mem_req     = rst & req_c;
    assign mem_timeout = rst & tmo_c;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_freeze && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_flush && (flush_cnt != '1))  flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the freeze/flush rules.
module tb_pipeline_ctrl;

    localparam int T     = 8;
    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_two_src, id_valid, fwd_en, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       branch_taken, mem_r_en, mem_w_en, mem_ready;
    logic       pc_freeze, if_freeze, id_freeze, exe_freeze, mem_freeze;
    logic       if_flush, id_flush, mem_req, mem_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif
    logic [8:0] obs;
    logic [8:0] exp_v;

    int total = 0;
    int bad   = 0;
    bit m_dead = 1'b0;
    int m_waited = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
        .fwd_en(fwd_en), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze), .if_freeze(if_freeze), .id_freeze(id_freeze),
        .exe_freeze(exe_freeze), .mem_freeze(mem_freeze), .if_flush(if_flush),
        .id_flush(id_flush), .mem_req(mem_req), .mem_timeout(mem_timeout)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    assign obs = {pc_freeze, if_freeze, id_freeze, exe_freeze, mem_freeze,
                  if_flush, id_flush, mem_req, mem_timeout};

    // Behavioural reference: list pending writers, then test each read port.
    function automatic bit model_raw();
        int writers[$];
        if (fwd_en) begin
            if (exe_wb_en && exe_mem_r_en) writers.push_back(int'(exe_dest));
        end else begin
            if (exe_wb_en) writers.push_back(int'(exe_dest));
            if (mem_wb_en) writers.push_back(int'(mem_dest));
        end
        foreach (writers[i]) begin
            if ((id_valid && int'(id_src1) == writers[i]) ||
                (id_two_src && int'(id_src2) == writers[i])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        if (m_waited > 0) return !mem_ready;
        return (mem_r_en || mem_w_en) && !mem_ready;
    endfunction

    function automatic logic [8:0] model_out();
        logic req;
        if (!rst)  return 9'b0;
        if (m_dead) return 9'b11111_00_0_1;
        req = (m_waited > 0) || mem_r_en || mem_w_en;
        if (model_stall())  return {5'b11111, 2'b00, req, 1'b0};
        if (branch_taken)   return {5'b00000, 2'b11, req, 1'b0};
        if (model_raw())    return {5'b11000, 2'b01, req, 1'b0};
        return {7'b0, req, 1'b0};
    endfunction

    task automatic model_update();
        if (!rst) begin
            m_dead   = 1'b0;
            m_waited = 0;
        end else if (!m_dead) begin
            if (model_stall()) begin
                if (m_waited == 0)      m_waited = 1;
                else if (m_waited == T) m_dead = 1'b1;
                else                    m_waited++;
            end else begin
                m_waited = 0;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; id_valid = 1'b0;
        fwd_en = 1'b0; exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0; branch_taken = 1'b0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        advance();
        advance();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        mem_r_en = 1'b1;
        #2;
        total++;
        if (obs !== 9'b0) begin
            bad++; $display("FAIL reset_hold got=%b want=%b", obs, 9'b0);
        end
        advance();
        rst = 1'b1;
        advance();
        advance();
        #2;
        total++;
        if (obs !== 9'b11111_00_1_0) begin
            bad++; $display("FAIL wait_before_rst got=%b want=%b", obs, 9'b11111_00_1_0);
        end
        rst = 1'b0;
        #1;
        total++;
        if (obs !== 9'b0) begin
            bad++; $display("FAIL rst_mid_wait got=%b want=%b", obs, 9'b0);
        end
        advance();
        set_idle();
        rst = 1'b1;
        #2;
        total++;
        if (obs !== 9'b0) begin
            bad++; $display("FAIL run_after_rst got=%b want=%b", obs, 9'b0);
        end
        advance();
    endtask

    task automatic test_raw();
        set_idle();
        fwd_en = 1'b1; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3;
        id_valid = 1'b1; id_src1 = 4'd3;
        #2;
        total++;
        if (obs !== 9'b11000_01_0_0) begin
            bad++; $display("FAIL load_use got=%b want=%b", obs, 9'b11000_01_0_0);
        end
        advance();
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_wb_en = 1'b1; mem_dest = 4'd3;
        #2;
        total++;
        if (obs !== 9'b0) begin
            bad++; $display("FAIL load_use_release got=%b want=%b", obs, 9'b0);
        end
        advance();
        fwd_en = 1'b0;
        #2;
        total++;
        if (obs !== 9'b11000_01_0_0) begin
            bad++; $display("FAIL nofwd_mem_hit got=%b want=%b", obs, 9'b11000_01_0_0);
        end
        advance();
        fwd_en = 1'b1; mem_wb_en = 1'b0; exe_wb_en = 1'b1; exe_dest = 4'd3;
        #2;
        total++;
        if (obs !== 9'b0) begin
            bad++; $display("FAIL fwd_alu_nostall got=%b want=%b", obs, 9'b0);
        end
        advance();
        fwd_en = 1'b0; id_src1 = 4'd9; exe_dest = 4'd6; id_src2 = 4'd6;
        id_two_src = 1'b0;
        #2;
        total++;
        if (obs !== 9'b0) begin
            bad++; $display("FAIL src2_unused got=%b want=%b", obs, 9'b0);
        end
        advance();
        id_two_src = 1'b1;
        #2;
        total++;
        if (obs !== 9'b11000_01_0_0) begin
            bad++; $display("FAIL src2_hit got=%b want=%b", obs, 9'b11000_01_0_0);
        end
        advance();
        set_idle();
    endtask

    task automatic test_mem_wait();
        int frz_n = 0;
        int req_n = 0;
        set_idle();
        mem_w_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            mem_ready = (c == 4);
            if (c == 5) mem_w_en = 1'b0;
            #2;
            exp_v = model_out();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL mem_wait_c%0d got=%b want=%b", c, obs, exp_v);
            end
            if (obs[8:4] == 5'b11111) frz_n++;
            if (mem_req) req_n++;
            advance();
        end
        total++;
        if (frz_n != 4) begin
            bad++; $display("FAIL mem_wait_freeze_cycles got=%0d want=4", frz_n);
        end
        total++;
        if (req_n != 5) begin
            bad++; $display("FAIL mem_wait_req_cycles got=%0d want=5", req_n);
        end
        set_idle();
    endtask

    task automatic test_branch();
        set_idle();
        branch_taken = 1'b1;
        exe_wb_en = 1'b1; exe_dest = 4'd2; id_valid = 1'b1; id_src1 = 4'd2;
        #2;
        total++;
        if (obs !== 9'b00000_11_0_0) begin
            bad++; $display("FAIL branch_over_raw got=%b want=%b", obs, 9'b00000_11_0_0);
        end
        advance();
        mem_r_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            total++;
            if (obs !== 9'b11111_00_1_0) begin
                bad++; $display("FAIL branch_frozen_c%0d got=%b want=%b", c, obs, 9'b11111_00_1_0);
            end
            advance();
        end
        mem_ready = 1'b1;
        #2;
        total++;
        if (obs !== 9'b00000_11_1_0) begin
            bad++; $display("FAIL branch_deferred got=%b want=%b", obs, 9'b00000_11_1_0);
        end
        advance();
        set_idle();
        advance();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_r_en = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c >= 10) begin
                mem_r_en = 1'b0; mem_ready = 1'b1;
            end
            exp_v = (c <= T) ? 9'b11111_00_1_0 : 9'b11111_00_0_1;
            #2;
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL timeout_c%0d got=%b want=%b", c, obs, exp_v);
            end
            advance();
        end
        do_reset();
        #2;
        total++;
        if (obs !== 9'b0) begin
            bad++; $display("FAIL timeout_cleared got=%b want=%b", obs, 9'b0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (m_dead && ($urandom_range(0, 3) == 0)) begin
                rst = 1'b0;
            end else begin
                rst = 1'b1;
            end
            fwd_en       = 1'($urandom_range(0, 1));
            id_src1      = 4'($urandom_range(0, 7));
            id_src2      = 4'($urandom_range(0, 7));
            id_valid     = 1'($urandom_range(0, 1));
            id_two_src   = 1'($urandom_range(0, 1));
            exe_dest     = 4'($urandom_range(0, 7));
            mem_dest     = 4'($urandom_range(0, 7));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 4) == 0);
            mem_r_en     = ($urandom_range(0, 3) == 0);
            mem_w_en     = ($urandom_range(0, 5) == 0);
            mem_ready    = ($urandom_range(0, 2) != 0);
            #2;
            exp_v = model_out();
            total++;
            if (obs !== exp_v) begin
                bad++; $display("FAIL random_c%0d got=%b want=%b", c, obs, exp_v);
            end
            advance();
        end
        rst = 1'b1;
        set_idle();
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exe_wb_en = 1'b1; exe_dest = 4'd5; id_valid = 1'b1; id_src1 = 4'd5;
            advance();
            set_idle();
            advance();
        end
        for (int k = 0; k < 2; k++) begin
            branch_taken = 1'b1;
            advance();
            set_idle();
            advance();
        end
        #2;
        total++;
        if (stall_cnt !== CNT_W'(3)) begin
            bad++; $display("FAIL perf_stall_cnt got=%0d want=3", stall_cnt);
        end
        total++;
        if (flush_cnt !== CNT_W'(2)) begin
            bad++; $display("FAIL perf_flush_cnt got=%0d want=2", flush_cnt);
        end
    endtask
`endif

    initial begin
        set_idle();
        test_reset();
        test_raw();
        test_mem_wait();
        test_branch();
        test_timeout();
        test_random();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
